// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin arbiter that shares one byte-serial UART transmitter
// among N requesters. It loads the winner's byte, follows tx_busy to the end of
// the frame, and then inserts an optional idle gap. A per-requester lock keeps
// ownership across multi-byte messages.
module uart_tx_arb #(
  parameter int unsigned N   = 4,
  parameter int unsigned GAP = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [8*N-1:0] data,
  input  logic [N-1:0]   lock,
  output logic [N-1:0]   ack,
  output logic [N-1:0]   grant,
  output logic           tx_send,
  output logic [7:0]     tx_data,
  input  logic           tx_busy,
  output logic           idle
);

  localparam int unsigned PW = $clog2(N);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SEND  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] owner_q, owner_d;
  logic          locked_q, locked_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [N-1:0]  ack_q, ack_d;
  logic          tx_send_q, tx_send_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          idle_q, idle_d;

  logic          hold;
  logic          win_found;
  logic [PW-1:0] win_idx;
  int unsigned   scan_idx;

  // Owner keeps exclusive eligibility while its lock input is still high.
  assign hold = locked_q & lock[owner_q];

  // Winner selection: only the owner while held, else round-robin from ptr.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = 0;
    if (hold) begin
      if (req[owner_q]) begin
        win_found = 1'b1;
        win_idx   = owner_q;
      end
    end else begin
      for (int unsigned k = 0; k < N; k++) begin
        scan_idx = (32'(ptr_q) + k) % N;
        if (!win_found && req[scan_idx]) begin
          win_found = 1'b1;
          win_idx   = PW'(scan_idx);
        end
      end
    end
  end

  // Next-state logic; every output is produced from a register.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    locked_d  = locked_q;
    cnt_d     = cnt_q;
    grant_d   = grant_q;
    ack_d     = '0;
    tx_send_d = 1'b0;
    tx_data_d = tx_data_q;
    unique case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          grant_d   = N'(1) << win_idx;
          ack_d     = N'(1) << win_idx;
          tx_send_d = 1'b1;
          tx_data_d = data[8*win_idx +: 8];
          ptr_d     = PW'((32'(win_idx) + 1) % N);
          owner_d   = win_idx;
          locked_d  = lock[win_idx];
          state_d   = ST_SEND;
        end else if (!hold) begin
          // A lock released with no pending request frees the line.
          grant_d  = '0;
          locked_d = 1'b0;
        end
      end
      ST_SEND: begin
        // tx_busy rises only after the load, so it is not looked at here.
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (!tx_busy) begin
          if (GAP > 0) begin
            cnt_d   = 4'(GAP - 1);
            state_d = ST_GAP;
          end else begin
            state_d = ST_IDLE;
            if (!locked_q) grant_d = '0;
          end
        end
      end
      ST_GAP: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_IDLE;
          if (!locked_q) grant_d = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    idle_d = (state_d == ST_IDLE) && !locked_d;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      owner_q   <= '0;
      locked_q  <= 1'b0;
      cnt_q     <= 4'd0;
      grant_q   <= '0;
      ack_q     <= '0;
      tx_send_q <= 1'b0;
      tx_data_q <= 8'd0;
      idle_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      locked_q  <= locked_d;
      cnt_q     <= cnt_d;
      grant_q   <= grant_d;
      ack_q     <= ack_d;
      tx_send_q <= tx_send_d;
      tx_data_q <= tx_data_d;
      idle_q    <= idle_d;
    end
  end

  assign ack     = ack_q;
  assign grant   = grant_q;
  assign tx_send = tx_send_q;
  assign tx_data = tx_data_q;
  assign idle    = idle_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: a transmitter model drives tx_busy, expected loads are
// queued when requests are raised and popped when tx_send fires.
module tb_uart_tx_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] data = '0;
  logic [3:0]  lock = '0;
  logic [3:0]  ack, grant;
  logic        tx_send;
  logic [7:0]  tx_data;
  logic        tx_busy = 1'b0;
  logic        idle;

  logic [3:0]  g_req = '0;
  logic [31:0] g_data = '0;
  logic [3:0]  g_lock = '0;
  logic [3:0]  g_ack, g_grant;
  logic        g_tx_send;
  logic [7:0]  g_tx_data;
  logic        g_tx_busy = 1'b0;
  logic        g_idle;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int stray = 0;
  int busy_cnt = 0;
  int g_busy_cnt = 0;

  typedef struct {
    logic [3:0] mask;
    logic [7:0] byt;
  } exp_t;
  exp_t sb_q[$];

  uart_tx_arb #(.N(4), .GAP(0)) dut (
    .clk(clk), .rst(rst), .req(req), .data(data), .lock(lock), .ack(ack),
    .grant(grant), .tx_send(tx_send), .tx_data(tx_data), .tx_busy(tx_busy),
    .idle(idle)
  );

  uart_tx_arb #(.N(4), .GAP(3)) dut_gap (
    .clk(clk), .rst(rst), .req(g_req), .data(g_data), .lock(g_lock), .ack(g_ack),
    .grant(g_grant), .tx_send(g_tx_send), .tx_data(g_tx_data), .tx_busy(g_tx_busy),
    .idle(g_idle)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter models: busy for 9 cycles starting the cycle after the load.
  always @(posedge clk) begin
    if (!rst) begin
      busy_cnt <= 0;
      tx_busy  <= 1'b0;
    end else if (tx_send) begin
      busy_cnt <= 9;
      tx_busy  <= 1'b1;
    end else if (busy_cnt > 1) begin
      busy_cnt <= busy_cnt - 1;
    end else begin
      busy_cnt <= 0;
      tx_busy  <= 1'b0;
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      g_busy_cnt <= 0;
      g_tx_busy  <= 1'b0;
    end else if (g_tx_send) begin
      g_busy_cnt <= 9;
      g_tx_busy  <= 1'b1;
    end else if (g_busy_cnt > 1) begin
      g_busy_cnt <= g_busy_cnt - 1;
    end else begin
      g_busy_cnt <= 0;
      g_tx_busy  <= 1'b0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard monitor: every load must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst && tx_send) begin
      if (sb_q.size() == 0) begin
        check_eq("sb_unexpected_send", {24'd0, tx_data}, 32'hffff_ffff);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check_eq("sb_tx_data", {24'd0, tx_data}, {24'd0, e.byt});
        check_eq("sb_ack", {28'd0, ack}, {28'd0, e.mask});
      end
    end
    if (rst && !tx_send && ack != 4'd0) stray++;
  end

  task automatic push_exp(input int i, input logic [7:0] b);
    exp_t e;
    e.mask = 4'(1 << i);
    e.byt  = b;
    sb_q.push_back(e);
  endtask

  task automatic raise(input int i, input logic [7:0] b, input logic lk);
    data[8*i +: 8] = b;
    lock[i] = lk;
    req[i] = 1'b1;
  endtask

  task automatic wait_ack(input int i, input string tag, output int c);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge clk);
      if (ack[i]) seen = 1'b1;
    end
    check_eq(tag, {31'd0, seen}, 32'd1);
    c = cyc;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c;
    int ts[5];
    int gc[2];
    bit seen;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_grant", {28'd0, grant}, 32'd0);
    check_eq("rst_ack", {28'd0, ack}, 32'd0);
    check_eq("rst_tx_send", {31'd0, tx_send}, 32'd0);
    check_eq("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check_eq("rst_idle", {31'd0, idle}, 32'd1);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Single requester, 1-cycle latency, grant held through the frame
    push_exp(2, 8'hA5);
    raise(2, 8'hA5, 1'b0);
    @(negedge clk);
    check_eq("single_send", {31'd0, tx_send}, 32'd1);
    check_eq("single_ack", {28'd0, ack}, 32'h4);
    req[2] = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("single_grant_t11", {28'd0, grant}, 32'h4);
    check_eq("single_idle_t11", {31'd0, idle}, 32'd0);
    @(negedge clk);
    check_eq("single_grant_t12", {28'd0, grant}, 32'd0);
    check_eq("single_idle_t12", {31'd0, idle}, 32'd1);

    // Round-robin from ptr=0 with every request re-raised after its ack
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      push_exp(i, 8'(8'h10 + i));
      raise(i, 8'(8'h10 + i), 1'b0);
    end
    push_exp(0, 8'h20);
    for (int k = 0; k < 5; k++) begin
      wait_ack(k % 4, "rr_ack", ts[k]);
      data[8*(k % 4) +: 8] = 8'(8'h20 + (k % 4));
    end
    req = '0;
    for (int k = 1; k < 5; k++) check_eq("rr_spacing", ts[k] - ts[k-1], 32'd12);

    // Lock keeps req0 as owner for two bytes while req1 waits
    pulse_reset();
    push_exp(0, 8'h11);
    push_exp(0, 8'h22);
    push_exp(1, 8'h33);
    raise(0, 8'h11, 1'b1);
    raise(1, 8'h33, 1'b0);
    wait_ack(0, "lock_ack0a", c);
    data[7:0] = 8'h22;
    wait_ack(0, "lock_ack0b", c);
    req[0] = 1'b0;
    lock[0] = 1'b0;
    wait_ack(1, "lock_ack1", c);
    req[1] = 1'b0;

    // Owner 0 locked but idle blocks req3 until lock[0] drops
    push_exp(0, 8'h44);
    push_exp(3, 8'h55);
    raise(0, 8'h44, 1'b1);
    wait_ack(0, "blk_ack0", c);
    req[0] = 1'b0;
    raise(3, 8'h55, 1'b0);
    repeat (20) @(negedge clk);
    check_eq("blk_grant", {28'd0, grant}, 32'h1);
    check_eq("blk_idle", {31'd0, idle}, 32'd0);
    check_eq("blk_no_send", {31'd0, tx_send}, 32'd0);
    lock[0] = 1'b0;
    @(negedge clk);
    check_eq("blk_release_ack", {28'd0, ack}, 32'h8);
    req[3] = 1'b0;

    // Reset while the transmitter is shifting
    push_exp(1, 8'h66);
    raise(1, 8'h66, 1'b0);
    wait_ack(1, "mid_ack", c);
    req[1] = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_grant", {28'd0, grant}, 32'd0);
    check_eq("mid_rst_send", {31'd0, tx_send}, 32'd0);
    check_eq("mid_rst_idle", {31'd0, idle}, 32'd1);
    rst = 1'b1;
    push_exp(1, 8'h77);
    push_exp(3, 8'h88);
    raise(1, 8'h77, 1'b0);
    raise(3, 8'h88, 1'b0);
    wait_ack(1, "post_rst_ack1", c);
    req[1] = 1'b0;
    wait_ack(3, "post_rst_ack3", c);
    req[3] = 1'b0;
    repeat (14) @(negedge clk);

    // GAP=3 instance: back-to-back loads 15 cycles apart
    g_data[7:0]  = 8'h99;
    g_data[15:8] = 8'hAA;
    g_req = 4'b0011;
    for (int n = 0; n < 2; n++) begin
      seen = 1'b0;
      for (int k = 0; k < 60 && !seen; k++) begin
        @(negedge clk);
        if (g_tx_send) seen = 1'b1;
      end
      check_eq("gap_send", {31'd0, seen}, 32'd1);
      gc[n] = cyc;
      check_eq("gap_byte", {24'd0, g_tx_data}, (n == 0) ? 32'h99 : 32'hAA);
      check_eq("gap_ack", {28'd0, g_ack}, 32'(1 << n));
      g_req[n] = 1'b0;
    end
    check_eq("gap_spacing", gc[1] - gc[0], 32'd15);

    repeat (5) @(negedge clk);
    check_eq("stray_ack", stray, 32'd0);
    check_eq("sb_drained", sb_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
